mem_access_stage: RTL and testbench

Pipeline memory stage sitting directly downstream of the execute/ALU stage and upstream of write-back. Takes the registered ALU result (address or value), store data and memory control bits, performs at most one aligned 64-bit-bus data access per instruction through a request/acknowledge data-cache port, and aligns and extends load data. Stalls the upstream pipeline while an access is outstanding. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage between execute and write-back.
// Issues at most one aligned 64-bit data-cache access per instruction over a
// req/ack port. It aligns and extends load data, and it stalls the upstream
// pipeline while an access is outstanding. Non-memory instructions pass
// through with one cycle of latency.
//
// Ports:
//   clk, reset (async, active-high)
//   inValid, inResult, inDataReg2, inMemRead, inMemWrite, inMemOrReg,
//   inRegWrite, inDestRegister, inLoadType, inStoreType, inFlush
//                                        : execute-stage outputs
//   dcReq, dcWrite, dcAddr, dcWdata, dcWstrb
//                                        : data-cache request (out)
//   dcAck, dcRdata                       : data-cache completion (in)
//   outStall                             : upstream must hold this cycle
//   outValid, outResult, outLoadData, outMemOrReg, outRegWrite,
//   outDestRegister, outMisaligned       : write-back outputs
module mem_access_stage #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    input  logic [BUS_DATA_WIDTH-1:0] inResult,
    input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic                      inMemOrReg,
    input  logic                      inRegWrite,
    input  logic [4:0]                inDestRegister,
    input  logic [2:0]                inLoadType,
    input  logic [1:0]                inStoreType,
    input  logic                      inFlush,
    output logic                      dcReq,
    output logic                      dcWrite,
    output logic [BUS_DATA_WIDTH-1:0] dcAddr,
    output logic [BUS_DATA_WIDTH-1:0] dcWdata,
    output logic [7:0]                dcWstrb,
    input  logic                      dcAck,
    input  logic [BUS_DATA_WIDTH-1:0] dcRdata,
    output logic                      outStall,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] outResult,
    output logic [BUS_DATA_WIDTH-1:0] outLoadData,
    output logic                      outMemOrReg,
    output logic                      outRegWrite,
    output logic [4:0]                outDestRegister,
    output logic                      outMisaligned
);
    localparam int W = BUS_DATA_WIDTH;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    state_t state_reg, state_next;

    logic [2:0]   off;
    logic [1:0]   size_code;
    logic         aligned;
    logic         is_mem;
    logic         accept;
    logic         misaligned;
    logic [7:0]   store_strb;
    logic [W-1:0] store_data;

    // Copy of the request held for the duration of BUSY
    logic         req_write_reg;
    logic [W-1:0] req_addr_reg;
    logic [W-1:0] req_wdata_reg;
    logic [7:0]   req_wstrb_reg;
    logic [2:0]   req_type_reg;
    logic [2:0]   req_off_reg;
    logic [W-1:0] wb_result_reg;
    logic         wb_mor_reg;
    logic         wb_rw_reg;
    logic [4:0]   wb_rd_reg;
    logic         flush_reg;

    logic [W-1:0] rdata_shifted;
    logic [W-1:0] load_value;

    assign off    = inResult[2:0];
    assign is_mem = inValid && (inMemRead || inMemWrite);

    // log2 of access size; load type 111 has low bits 11, so it aligns like ld
    assign size_code = inMemWrite ? inStoreType : inLoadType[1:0];

    always_comb begin
        case (size_code)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = (off[0] == 1'b0);
            2'b10:   aligned = (off[1:0] == 2'b00);
            default: aligned = (off == 3'b000);
        endcase
    end

    always_comb begin
        case (inStoreType)
            2'b00:   store_strb = 8'h01 << off;
            2'b01:   store_strb = 8'h03 << off;
            2'b10:   store_strb = 8'h0F << off;
            default: store_strb = 8'hFF;
        endcase
    end

    assign store_data = inDataReg2 << {off, 3'b000};
    assign accept     = (state_reg == IDLE) && is_mem && aligned && !inFlush;
    assign misaligned = is_mem && !aligned;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (dcAck)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request outputs. Gated by reset so an abandoned request drops at once,
    // even if upstream still presents a memory op while reset is held.
    always_comb begin
        dcReq    = 1'b0;
        dcWrite  = 1'b0;
        dcAddr   = '0;
        dcWdata  = '0;
        dcWstrb  = 8'h00;
        outStall = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dcReq    = 1'b1;
                        dcWrite  = inMemWrite;
                        dcAddr   = {inResult[W-1:3], 3'b000};
                        dcWdata  = inMemWrite ? store_data : '0;
                        dcWstrb  = inMemWrite ? store_strb : 8'h00;
                        outStall = 1'b1;
                    end
                end
                BUSY: begin
                    dcReq    = 1'b1;
                    dcWrite  = req_write_reg;
                    dcAddr   = req_addr_reg;
                    dcWdata  = req_wdata_reg;
                    dcWstrb  = req_wstrb_reg;
                    outStall = !dcAck;
                end
                default: ;
            endcase
        end
    end

    // Load alignment and extension from the latched offset and type
    assign rdata_shifted = dcRdata >> {req_off_reg, 3'b000};

    always_comb begin
        case (req_type_reg)
            3'b000:  load_value = {{(W-8){rdata_shifted[7]}},   rdata_shifted[7:0]};
            3'b001:  load_value = {{(W-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b010:  load_value = {{(W-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
            3'b100:  load_value = {{(W-8){1'b0}},  rdata_shifted[7:0]};
            3'b101:  load_value = {{(W-16){1'b0}}, rdata_shifted[15:0]};
            3'b110:  load_value = {{(W-32){1'b0}}, rdata_shifted[31:0]};
            default: load_value = rdata_shifted;
        endcase
    end

    // Request latch and write-back registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_write_reg   <= 1'b0;
            req_addr_reg    <= '0;
            req_wdata_reg   <= '0;
            req_wstrb_reg   <= 8'h00;
            req_type_reg    <= 3'b000;
            req_off_reg     <= 3'b000;
            wb_result_reg   <= '0;
            wb_mor_reg      <= 1'b0;
            wb_rw_reg       <= 1'b0;
            wb_rd_reg       <= 5'd0;
            flush_reg       <= 1'b0;
            outValid        <= 1'b0;
            outResult       <= '0;
            outLoadData     <= '0;
            outMemOrReg     <= 1'b0;
            outRegWrite     <= 1'b0;
            outDestRegister <= 5'd0;
            outMisaligned   <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (accept) begin
                req_write_reg <= inMemWrite;
                req_addr_reg  <= {inResult[W-1:3], 3'b000};
                req_wdata_reg <= inMemWrite ? store_data : '0;
                req_wstrb_reg <= inMemWrite ? store_strb : 8'h00;
                req_type_reg  <= inLoadType;
                req_off_reg   <= off;
                wb_result_reg <= inResult;
                wb_mor_reg    <= inMemOrReg;
                wb_rw_reg     <= inRegWrite;
                wb_rd_reg     <= inDestRegister;
                flush_reg     <= 1'b0;
                outValid      <= 1'b0;
                outRegWrite   <= 1'b0;
                outMisaligned <= 1'b0;
            end else begin
                // Pass-through: non-memory, invalid, flushed or misaligned
                outValid        <= inValid && !inFlush;
                outResult       <= inResult;
                outMemOrReg     <= inMemOrReg;
                outRegWrite     <= inRegWrite && !inFlush && !misaligned;
                outDestRegister <= inDestRegister;
                outMisaligned   <= misaligned && !inFlush;
            end
        end else begin
            if (dcAck) begin
                // A flush during BUSY cannot cancel the bus access; it only
                // kills the write-back of the completed instruction.
                outValid        <= !(flush_reg || inFlush);
                outResult       <= wb_result_reg;
                outMemOrReg     <= wb_mor_reg;
                outRegWrite     <= wb_rw_reg && !(flush_reg || inFlush);
                outDestRegister <= wb_rd_reg;
                outMisaligned   <= 1'b0;
                flush_reg       <= 1'b0;
                if (!req_write_reg) begin
                    outLoadData <= load_value;
                end
            end else begin
                flush_reg     <= flush_reg || inFlush;
                outValid      <= 1'b0;
                outRegWrite   <= 1'b0;
                outMisaligned <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level driver with a
// cache responder, a behavioural model checked every cycle, and directed
// literal expectations from the test plan.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [63:0] inResult, inDataReg2;
    logic        inMemRead, inMemWrite, inMemOrReg, inRegWrite;
    logic [4:0]  inDestRegister;
    logic [2:0]  inLoadType;
    logic [1:0]  inStoreType;
    logic        inFlush;
    logic        dcReq, dcWrite;
    logic [63:0] dcAddr, dcWdata;
    logic [7:0]  dcWstrb;
    logic        dcAck;
    logic [63:0] dcRdata;
    logic        outStall, outValid;
    logic [63:0] outResult, outLoadData;
    logic        outMemOrReg, outRegWrite;
    logic [4:0]  outDestRegister;
    logic        outMisaligned;

    int checks = 0;
    int errors = 0;
    int txn_count = 0;
    int last_stalls, last_reqs;
    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_wstrb;

    mem_access_stage #(.BUS_DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .inValid(inValid), .inResult(inResult), .inDataReg2(inDataReg2),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inMemOrReg(inMemOrReg), .inRegWrite(inRegWrite),
        .inDestRegister(inDestRegister), .inLoadType(inLoadType),
        .inStoreType(inStoreType), .inFlush(inFlush),
        .dcReq(dcReq), .dcWrite(dcWrite), .dcAddr(dcAddr), .dcWdata(dcWdata),
        .dcWstrb(dcWstrb), .dcAck(dcAck), .dcRdata(dcRdata),
        .outStall(outStall), .outValid(outValid), .outResult(outResult),
        .outLoadData(outLoadData), .outMemOrReg(outMemOrReg),
        .outRegWrite(outRegWrite), .outDestRegister(outDestRegister),
        .outMisaligned(outMisaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic int acc_size(input logic mw, input logic [2:0] lt, input logic [1:0] st);
        if (mw) begin
            case (st)
                2'd0: return 1;
                2'd1: return 2;
                2'd2: return 4;
                default: return 8;
            endcase
        end
        case (lt)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [63:0] a, input int sz);
        return ((a % 64'(sz)) == 64'd0);
    endfunction

    function automatic logic [7:0] strb_of(input int sz, input int o);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 8; i++) if (i >= o && i < o + sz) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] load_of(input logic [63:0] rd, input int o, input logic [2:0] lt);
        logic [63:0] v, one, mask;
        int sz, bits;
        logic sgn;
        v   = rd >> (8 * o);
        sz  = acc_size(1'b0, lt, 2'b00);
        sgn = (lt == 3'd0 || lt == 3'd1 || lt == 3'd2);
        if (sz < 8) begin
            bits = 8 * sz;
            one  = 64'd1;
            mask = (one << bits) - 64'd1;
            v    = v & mask;
            if (sgn && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Model state: one outstanding instruction plus expected write-back regs
    logic        m_busy, m_pw, m_pmor, m_prw, m_pflush;
    logic [63:0] m_paddr, m_pwdata, m_pres;
    logic [7:0]  m_pstrb;
    logic [2:0]  m_plt;
    int          m_poff;
    logic [4:0]  m_prd;
    logic        e_valid, e_mor, e_rw, e_mis;
    logic [63:0] e_res, e_load;
    logic [4:0]  e_rd;

    always @(negedge clk) begin
        logic        x_req, x_wr, x_stall, is_m, iss, mis, fl;
        logic [63:0] x_addr, x_wdata;
        logic [7:0]  x_strb;
        int          sz, o;
        if (reset) begin
            m_busy = 0; m_pflush = 0;
            e_valid = 0; e_mor = 0; e_rw = 0; e_mis = 0;
            e_res = 0; e_load = 0; e_rd = 0;
            x_req = 0; x_wr = 0; x_stall = 0; x_addr = 0; x_wdata = 0; x_strb = 0;
            is_m = 0; iss = 0; mis = 0; sz = 1; o = 0;
        end else if (!m_busy) begin
            sz   = acc_size(inMemWrite, inLoadType, inStoreType);
            o    = int'(inResult % 64'd8);
            is_m = inValid && (inMemRead || inMemWrite);
            iss  = is_m && is_aligned(inResult, sz) && !inFlush;
            mis  = is_m && !is_aligned(inResult, sz);
            x_req   = iss;
            x_wr    = iss && inMemWrite;
            x_addr  = iss ? inResult - 64'(o) : 64'd0;
            x_wdata = (iss && inMemWrite) ? inDataReg2 << (8 * o) : 64'd0;
            x_strb  = (iss && inMemWrite) ? strb_of(sz, o) : 8'h00;
            x_stall = iss;
        end else begin
            x_req = 1; x_wr = m_pw; x_addr = m_paddr; x_wdata = m_pwdata;
            x_strb = m_pstrb; x_stall = !dcAck;
        end
        chk("dcReq", dcReq, x_req);
        chk("dcWrite", dcWrite, x_wr);
        chk("dcAddr", dcAddr, x_addr);
        chk("dcWdata", dcWdata, x_wdata);
        chk("dcWstrb", dcWstrb, x_strb);
        chk("outStall", outStall, x_stall);
        chk("outValid", outValid, e_valid);
        chk("outResult", outResult, e_res);
        chk("outLoadData", outLoadData, e_load);
        chk("outMemOrReg", outMemOrReg, e_mor);
        chk("outRegWrite", outRegWrite, e_rw);
        chk("outDestRegister", outDestRegister, e_rd);
        chk("outMisaligned", outMisaligned, e_mis);
        if (!reset) begin
            if (!m_busy) begin
                if (iss) begin
                    m_busy = 1; m_pw = inMemWrite; m_paddr = x_addr; m_pwdata = x_wdata;
                    m_pstrb = x_strb; m_plt = inLoadType; m_poff = o; m_pres = inResult;
                    m_pmor = inMemOrReg; m_prw = inRegWrite; m_prd = inDestRegister;
                    m_pflush = 0;
                    e_valid = 0; e_rw = 0; e_mis = 0;
                end else begin
                    e_valid = inValid && !inFlush;
                    e_res = inResult; e_mor = inMemOrReg; e_rd = inDestRegister;
                    e_rw  = inRegWrite && !inFlush && !mis;
                    e_mis = mis && !inFlush;
                end
            end else begin
                m_pflush = m_pflush || inFlush;
                if (dcAck) begin
                    fl = m_pflush;
                    m_busy = 0;
                    e_valid = !fl; e_res = m_pres; e_mor = m_pmor;
                    e_rw = m_prw && !fl; e_rd = m_prd; e_mis = 0;
                    if (!m_pw) e_load = load_of(dcRdata, m_poff, m_plt);
                end else begin
                    e_valid = 0; e_rw = 0; e_mis = 0;
                end
            end
        end
    end

    // ---------------- driver / cache responder ----------------
    // Entered and left at posedge+1. Holds the instruction for as long as the
    // stage is expected to stall, and acks 'lat' cycles after the first request.
    task automatic run_instr(input logic v, input logic [63:0] res, input logic [63:0] d2,
                             input logic mr, input logic mw, input logic mor, input logic rw,
                             input logic [4:0] rd, input logic [2:0] lt, input logic [1:0] st,
                             input int lat, input int flush_at, input logic [63:0] rdata);
        logic acc;
        inValid = v; inResult = res; inDataReg2 = d2; inMemRead = mr; inMemWrite = mw;
        inMemOrReg = mor; inRegWrite = rw; inDestRegister = rd; inLoadType = lt;
        inStoreType = st; inFlush = (flush_at == 0); dcAck = 0;
        acc = v && (mr || mw) && is_aligned(res, acc_size(mw, lt, st)) && (flush_at != 0);
        last_stalls = 0; last_reqs = 0;
        txn_count++;
        $display("txn %0d: v=%0d rd=%0d wr=%0d addr=%h lt=%0d st=%0d lat=%0d flush_at=%0d accepted=%0d",
                 txn_count, v, mr, mw, res, lt, st, lat, flush_at, acc);
        if (!acc) begin
            @(negedge clk);
            if (outStall) last_stalls++;
            if (dcReq) last_reqs++;
            @(posedge clk); #1;
        end else begin
            for (int c = 0; c <= lat; c++) begin
                inFlush = (c == flush_at);
                dcAck   = (c == lat);
                dcRdata = (c == lat) ? rdata : {$urandom, $urandom};
                @(negedge clk);
                if (outStall) last_stalls++;
                if (dcReq) last_reqs++;
                if (c == 0) begin
                    cap_addr = dcAddr; cap_wdata = dcWdata; cap_wstrb = dcWstrb;
                end
                @(posedge clk); #1;
            end
        end
        dcAck = 0; inFlush = 0; inValid = 0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a;
        int kind, lat, fa, sz;
        reset = 1; inValid = 0; inResult = 0; inDataReg2 = 0; inMemRead = 0; inMemWrite = 0;
        inMemOrReg = 0; inRegWrite = 0; inDestRegister = 0; inLoadType = 0; inStoreType = 0;
        inFlush = 0; dcAck = 0; dcRdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("reset_outValid", outValid, 0);
        chk("reset_dcReq", dcReq, 0);

        // ALU pass-through
        run_instr(1, 64'h1234, 0, 0, 0, 0, 1, 5'd5, 3'd0, 2'd0, 1, -1, 0);
        chk("alu_valid", outValid, 1);
        chk("alu_result", outResult, 64'h1234);
        chk("alu_rd", outDestRegister, 5);
        chk("alu_no_req", last_reqs, 0);

        // sh to 0x1006
        run_instr(1, 64'h1006, 64'hBEEF, 0, 1, 0, 0, 5'd0, 3'd0, 2'd1, 2, -1, 0);
        chk("sh_addr", cap_addr, 64'h1000);
        chk("sh_wstrb", cap_wstrb, 8'hC0);
        chk("sh_wdata_hi", cap_wdata >> 48, 64'hBEEF);
        chk("sh_stalls", last_stalls, 2);

        // lb / lbu at 0x2003
        run_instr(1, 64'h2003, 0, 1, 0, 1, 1, 5'd7, 3'd0, 2'd0, 3, -1, 64'h00000000_80000000);
        chk("lb_data", outLoadData, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_stalls", last_stalls, 3);
        chk("lb_valid", outValid, 1);
        run_instr(1, 64'h2003, 0, 1, 0, 1, 1, 5'd7, 3'd4, 2'd0, 3, -1, 64'h00000000_80000000);
        chk("lbu_data", outLoadData, 64'h80);

        // misaligned lw
        run_instr(1, 64'h2002, 0, 1, 0, 1, 1, 5'd9, 3'd2, 2'd0, 1, -1, 0);
        chk("lw_mis_no_req", last_reqs, 0);
        chk("lw_mis_flag", outMisaligned, 1);
        chk("lw_mis_rw", outRegWrite, 0);
        @(posedge clk); #1;
        chk("lw_mis_one_cycle", outMisaligned, 0);

        // ld with flush during BUSY
        run_instr(1, 64'h4000, 0, 1, 0, 1, 1, 5'd3, 3'd3, 2'd0, 3, 1, 64'h1111);
        chk("ldfl_reqs", last_reqs, 4);
        chk("ldfl_valid", outValid, 0);
        chk("ldfl_rw", outRegWrite, 0);

        // reset while BUSY
        inValid = 1; inResult = 64'h5008; inMemRead = 1; inMemWrite = 0; inLoadType = 3'd3;
        inRegWrite = 1; inFlush = 0; dcAck = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_req", dcReq, 1);
        #1 reset = 1;
        #1;
        chk("rst_async_req", dcReq, 0);
        chk("rst_async_stall", outStall, 0);
        inValid = 0; inMemRead = 0;
        @(posedge clk); @(posedge clk); #1 reset = 0;
        run_instr(1, 64'h3000, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 0, 5'd0, 3'd0, 2'd3, 1, -1, 0);
        chk("sd_wstrb", cap_wstrb, 8'hFF);
        chk("sd_addr", cap_addr, 64'h3000);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            a = {$urandom, $urandom};
            lat = $urandom_range(1, 4);
            fa = ($urandom_range(0, 6) == 0) ? $urandom_range(0, lat) : -1;
            inLoadType = 3'($urandom_range(0, 7));
            inStoreType = 2'($urandom_range(0, 3));
            sz = acc_size(kind == 2, inLoadType, inStoreType);
            if ($urandom_range(0, 9) < 6) a = a - (a % 64'(sz));
            run_instr($urandom_range(0, 9) != 0, a, {$urandom, $urandom},
                      kind == 1, kind == 2, 1'($urandom), 1'($urandom), 5'($urandom),
                      inLoadType, inStoreType, lat, fa, {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
